matrix_mult_engine: RTL and testbench
=====================================

// Module: matrix_mult_engine
// PURPOSE
//  Parametrised NxM * MxP integer matrix-multiply engine. Fetches A and B from two
//  synchronous read ports and computes each C element with a pipelined MAC, one
//  product per cycle. Streams C in row-major order over a valid/ready port plus a
//  write port to matrix_c_addr. Adds signed mode, transposed-B, overflow flag, abort.
// PARAMETERS
//  ADDR_WIDTH  12  word-address width of all memory ports
//  DATA_WIDTH  32  element width of A, B and C
//  DIM_WIDTH   4   width of N, M, P (max dimension 2**DIM_WIDTH-1)
//  ACC_WIDTH   2*DATA_WIDTH+DIM_WIDTH  internal accumulator width
// PORTS
//  clk            in   1           clock, rising edge
//  rst_n          in   1           asynchronous active-low reset
//  start          in   1           1-cycle request; sampled only in IDLE
//  abort          in   1           synchronous cancel of a running job
//  signed_mode    in   1           1: two's-complement operands; latched at start
//  transpose_b    in   1           1: B stored column-major; latched at start
//  matrix_a_addr  in   ADDR_WIDTH  base of A, row-major, stride M
//  matrix_b_addr  in   ADDR_WIDTH  base of B, row-major stride P (or col-major stride M)
//  matrix_c_addr  in   ADDR_WIDTH  base of C, row-major, stride P
//  N, M, P        in   DIM_WIDTH   dimensions; latched at start
//  a_rd_en/a_rd_addr  out 1/ADDR_WIDTH  A read request; a_rd_data valid next cycle
//  a_rd_data      in   DATA_WIDTH
//  b_rd_en/b_rd_addr  out 1/ADDR_WIDTH  B read request; b_rd_data valid next cycle
//  b_rd_data      in   DATA_WIDTH
//  res_valid      out  1           result element available
//  res_ready      in   1           consumer accepts when valid&ready
//  result_out     out  DATA_WIDTH  C[i][j], low DATA_WIDTH bits of accumulator
//  res_row/res_col out DIM_WIDTH   indices i, j of result_out
//  c_wr_en/c_wr_addr/c_wr_data  out 1/ADDR_WIDTH/DATA_WIDTH  fires on each accept
//  busy, done, err, ovf  out 1     status; ovf sticky per job
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters, accumulator, flags cleared.
//  - Addresses: A[i][k]=a+i*M+k; B[k][j]=b+k*P+j (transpose_b: b+j*M+k);
//    C[i][j]=c+i*P+j; all modulo 2**ADDR_WIDTH (wrap, no error).
//  - FSM IDLE -> FETCH -> DRAIN -> EMIT -> (FETCH | DONE) -> IDLE.
//    IDLE: start -> latch inputs, clear ovf/err, busy=1 next cycle.
//    FETCH: a_rd_en=b_rd_en=1 for k=0..M-1, one per cycle, back to back.
//    DRAIN: 1 cycle; last product accumulated (1-cycle read latency).
//    EMIT: res_valid=1, data/indices stable until accepted; c_wr_en=valid&ready.
//      On accept: j++ (wrap to 0, i++); last element -> DONE, else FETCH.
//    DONE: done=1 for exactly 1 cycle, busy=0 same cycle, -> IDLE.
//  - Latency per element M+1 cycles + backpressure; first res_valid at cycle M+2
//    after start.
//  - Accumulator cleared at each element's k=0; products sign/zero-extended per
//    signed_mode to ACC_WIDTH; no overflow inside accumulator.
//  - ovf set if accumulator is not representable in DATA_WIDTH (signed or unsigned
//    per mode) for any emitted element; result still truncated.
//  - N, M or P == 0: no reads, no results; DONE next cycle with err=1.
//  - start while busy: ignored. abort: -> IDLE next cycle, res_valid/c_wr_en drop,
//    no done pulse; wins over simultaneous accept. abort in IDLE: no effect.
//  - rst_n low mid-job: immediate return to reset state, no done.
//  - err/ovf hold until next accepted start.
// STRUCTURE
//  - mm_pkg: FSM state enum, ACC_WIDTH function, address-offset helper function.
//  - Sub-module mm_mac_unit: registered multiply, accumulate, clear, signed mode,
//    overflow check; top holds FSM, index counters, address generation, output reg.
// TESTING
//  - 2x2x2 unsigned A=[1 2;3 4], B=[5 6;7 8] -> stream 19,22,43,50; rows/cols
//    0/0,0/1,1/0,1/1; c_wr_addr c..c+3; done 1 cycle.
//  - 3x4x2 signed A with -1 entries, transpose_b=1 -> matches software model;
//    B addresses column-major.
//  - res_ready low 5 cycles per element, random toggling -> data/indices stable,
//    no loss or duplication, one c_wr_en per element.
//  - signed_mode=0, A=B=32'hFFFF_FFFF, 1x1x1 -> result_out=1, ovf=1.
//  - M=0 -> no a_rd_en/b_rd_en, done next cycle, err=1.
//  - abort mid-FETCH, then rst_n low mid-EMIT -> IDLE, outputs 0, no done; next
//    start completes normally.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply engine.
// Contents:
//   mm_state_e  - engine FSM states
//   acc_width   - accumulator width that cannot overflow for any legal M
//   addr_offset - major*stride + minor, used for every A/B/C element address
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } mm_state_e;

    // A full product needs 2*DATA_WIDTH bits; summing up to 2**DIM_WIDTH-1
    // of them needs DIM_WIDTH more.
    function automatic int acc_width(input int data_width, input int dim_width);
        return 2 * data_width + dim_width;
    endfunction

    // Callers truncate the result to their address width, which gives the
    // modulo-2**ADDR_WIDTH wrap for free.
    function automatic logic [31:0] addr_offset(input logic [31:0] major,
                                                input logic [31:0] stride,
                                                input logic [31:0] minor);
        return major * stride + minor;
    endfunction

endpackage

// File: rtl/mm_mac_unit.sv
// Multiply-accumulate unit for one C element.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   en               a_data/b_data hold a valid operand pair this cycle
//   clear            this pair is k=0: restart the sum instead of adding
//   signed_mode      1: operands are two's complement, 0: unsigned
//   a_data, b_data   operands straight from the memory read ports
//   result           low DATA_WIDTH bits of the accumulator
//   ovf              accumulator not representable in DATA_WIDTH for the mode
module mm_mac_unit
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = acc_width(32, 4)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ovf
);

    localparam int EXT = ACC_WIDTH - DATA_WIDTH;

    logic [ACC_WIDTH-1:0] a_ext;
    logic [ACC_WIDTH-1:0] b_ext;
    logic [ACC_WIDTH-1:0] product;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [EXT:0]         sign_bits;

    // Extending both operands to the accumulator width and keeping only the
    // low ACC_WIDTH bits of the product gives the exact signed or unsigned
    // product, since the true product always fits.
    always_comb begin
        a_ext   = {{EXT{signed_mode & a_data[DATA_WIDTH-1]}}, a_data};
        b_ext   = {{EXT{signed_mode & b_data[DATA_WIDTH-1]}}, b_data};
        product = a_ext * b_ext;
        acc_d   = acc_q;
        if (en) begin
            acc_d = (clear ? '0 : acc_q) + product;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Signed fits when every bit from the DATA_WIDTH sign bit upwards agrees;
    // unsigned fits when everything above DATA_WIDTH is zero.
    always_comb begin
        sign_bits = acc_q[ACC_WIDTH-1:DATA_WIDTH-1];
        result    = acc_q[DATA_WIDTH-1:0];
        if (signed_mode) begin
            ovf = !((&sign_bits) || !(|sign_bits));
        end else begin
            ovf = |acc_q[ACC_WIDTH-1:DATA_WIDTH];
        end
    end

endmodule

// File: rtl/matrix_mult_engine.sv
// NxM * MxP integer matrix-multiply engine.
// Reads A and B through two synchronous read ports (data one cycle after the
// request), accumulates one product per cycle and streams each C element in
// row-major order over a valid/ready port, mirrored onto a C write port.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, abort                     job request (IDLE only) / cancel
//   signed_mode, transpose_b         operand format, B layout (latched)
//   matrix_a/b/c_addr, N, M, P       base addresses and dimensions (latched)
//   a_rd_*, b_rd_*                   A and B read ports
//   res_valid/res_ready/result_out   result stream, with res_row/res_col
//   c_wr_en/c_wr_addr/c_wr_data      C write, one per accepted element
//   busy, done, err, ovf             status
module matrix_mult_engine
    import mm_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 4,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, DIM_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  signed_mode,
    input  logic                  transpose_b,
    input  logic [ADDR_WIDTH-1:0] matrix_a_addr,
    input  logic [ADDR_WIDTH-1:0] matrix_b_addr,
    input  logic [ADDR_WIDTH-1:0] matrix_c_addr,
    input  logic [DIM_WIDTH-1:0]  N,
    input  logic [DIM_WIDTH-1:0]  M,
    input  logic [DIM_WIDTH-1:0]  P,
    output logic                  a_rd_en,
    output logic [ADDR_WIDTH-1:0] a_rd_addr,
    input  logic [DATA_WIDTH-1:0] a_rd_data,
    output logic                  b_rd_en,
    output logic [ADDR_WIDTH-1:0] b_rd_addr,
    input  logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic [DIM_WIDTH-1:0]  res_row,
    output logic [DIM_WIDTH-1:0]  res_col,
    output logic                  c_wr_en,
    output logic [ADDR_WIDTH-1:0] c_wr_addr,
    output logic [DATA_WIDTH-1:0] c_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ovf
);

    mm_state_e             state_q, state_d;
    logic [DIM_WIDTH-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DIM_WIDTH-1:0]  n_q, n_d, m_q, m_d, p_q, p_d;
    logic [ADDR_WIDTH-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
    logic                  signed_q, signed_d, transpose_q, transpose_d;
    logic                  err_q, err_d, ovf_q, ovf_d;
    logic                  rd_valid_q, rd_valid_d, rd_first_q, rd_first_d;
    logic [DATA_WIDTH-1:0] mac_result;
    logic                  mac_ovf;
    logic [ADDR_WIDTH-1:0] a_off, b_off, c_off;
    logic                  emit, accept;

    // The read issued in a FETCH cycle returns data one cycle later, so the
    // MAC enable and its k=0 clear are the FETCH controls delayed by one.
    mm_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (rd_valid_q),
        .clear       (rd_first_q),
        .signed_mode (signed_q),
        .a_data      (a_rd_data),
        .b_data      (b_rd_data),
        .result      (mac_result),
        .ovf         (mac_ovf)
    );

    assign emit   = (state_q == ST_EMIT);
    assign accept = emit && res_ready && !abort;

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        n_d         = n_q;
        m_d         = m_q;
        p_d         = p_q;
        a_base_d    = a_base_q;
        b_base_d    = b_base_q;
        c_base_d    = c_base_q;
        signed_d    = signed_q;
        transpose_d = transpose_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        rd_valid_d  = 1'b0;
        rd_first_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d         = N;
                    m_d         = M;
                    p_d         = P;
                    a_base_d    = matrix_a_addr;
                    b_base_d    = matrix_b_addr;
                    c_base_d    = matrix_c_addr;
                    signed_d    = signed_mode;
                    transpose_d = transpose_b;
                    i_d         = '0;
                    j_d         = '0;
                    k_d         = '0;
                    ovf_d       = 1'b0;
                    err_d       = 1'b0;
                    if (N == '0 || M == '0 || P == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_valid_d = 1'b1;
                    rd_first_d = (k_q == '0);
                    if (k_q == m_q - 1'b1) begin
                        k_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = abort ? ST_IDLE : ST_EMIT;
            end
            ST_EMIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    ovf_d = ovf_q | mac_ovf;
                    if (j_q == p_q - 1'b1) begin
                        j_d = '0;
                        if (i_q == n_q - 1'b1) begin
                            state_d = ST_DONE;
                        end else begin
                            i_d     = i_q + 1'b1;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        j_d     = j_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            n_q         <= '0;
            m_q         <= '0;
            p_q         <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            c_base_q    <= '0;
            signed_q    <= 1'b0;
            transpose_q <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_first_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            n_q         <= n_d;
            m_q         <= m_d;
            p_q         <= p_d;
            a_base_q    <= a_base_d;
            b_base_q    <= b_base_d;
            c_base_q    <= c_base_d;
            signed_q    <= signed_d;
            transpose_q <= transpose_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            rd_valid_q  <= rd_valid_d;
            rd_first_q  <= rd_first_d;
        end
    end

    // Data-carrying outputs are forced to zero outside the states that
    // qualify them, so an idle or aborted engine presents an all-zero bus.
    always_comb begin
        a_off = ADDR_WIDTH'(addr_offset(32'(i_q), 32'(m_q), 32'(k_q)));
        if (transpose_q) begin
            b_off = ADDR_WIDTH'(addr_offset(32'(j_q), 32'(m_q), 32'(k_q)));
        end else begin
            b_off = ADDR_WIDTH'(addr_offset(32'(k_q), 32'(p_q), 32'(j_q)));
        end
        c_off = ADDR_WIDTH'(addr_offset(32'(i_q), 32'(p_q), 32'(j_q)));

        a_rd_en    = (state_q == ST_FETCH);
        b_rd_en    = (state_q == ST_FETCH);
        a_rd_addr  = a_rd_en ? a_base_q + a_off : '0;
        b_rd_addr  = b_rd_en ? b_base_q + b_off : '0;
        res_valid  = emit;
        result_out = emit ? mac_result : '0;
        res_row    = emit ? i_q : '0;
        res_col    = emit ? j_q : '0;
        c_wr_en    = accept;
        c_wr_addr  = accept ? c_base_q + c_off : '0;
        c_wr_data  = accept ? mac_result : '0;
        busy       = (state_q == ST_FETCH) || (state_q == ST_DRAIN) || emit;
        done       = (state_q == ST_DONE);
        err        = err_q;
        ovf        = ovf_q;
    end

endmodule

// File: tb/tb_matrix_mult_engine.sv
// Self-checking bench for matrix_mult_engine.
// Models the A/B memories as synchronous-read arrays, computes every expected
// C element with a software model when a job is started and compares the
// stream, read addresses and status against it as the engine produces them.
module tb_matrix_mult_engine;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int DIMW = 4;

    typedef struct {
        logic [DW-1:0]   data;
        logic [DIMW-1:0] row;
        logic [DIMW-1:0] col;
        logic [AW-1:0]   addr;
    } res_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, abort, signed_mode, transpose_b;
    logic [AW-1:0]   matrix_a_addr, matrix_b_addr, matrix_c_addr;
    logic [DIMW-1:0] N, M, P;
    logic            a_rd_en, b_rd_en;
    logic [AW-1:0]   a_rd_addr, b_rd_addr;
    logic [DW-1:0]   a_rd_data, b_rd_data;
    logic            res_valid, res_ready;
    logic [DW-1:0]   result_out;
    logic [DIMW-1:0] res_row, res_col;
    logic            c_wr_en;
    logic [AW-1:0]   c_wr_addr;
    logic [DW-1:0]   c_wr_data;
    logic            busy, done, err, ovf;

    logic [DW-1:0]   mem_a [4096];
    logic [DW-1:0]   mem_b [4096];

    res_t            exp_q[$];
    logic [AW-1:0]   exp_a_q[$];
    logic [AW-1:0]   exp_b_q[$];
    logic            exp_ovf;
    int              exp_reads;
    int              checks = 0;
    int              errors = 0;
    int              done_cyc;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
        if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
    end

    matrix_mult_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .signed_mode   (signed_mode),
        .transpose_b   (transpose_b),
        .matrix_a_addr (matrix_a_addr),
        .matrix_b_addr (matrix_b_addr),
        .matrix_c_addr (matrix_c_addr),
        .N             (N),
        .M             (M),
        .P             (P),
        .a_rd_en       (a_rd_en),
        .a_rd_addr     (a_rd_addr),
        .a_rd_data     (a_rd_data),
        .b_rd_en       (b_rd_en),
        .b_rd_addr     (b_rd_addr),
        .b_rd_data     (b_rd_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .result_out    (result_out),
        .res_row       (res_row),
        .res_col       (res_col),
        .c_wr_en       (c_wr_en),
        .c_wr_addr     (c_wr_addr),
        .c_wr_data     (c_wr_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .ovf           (ovf)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // Drives one start pulse (raised here, dropped by the caller's next step)
    // and pushes the expected reads and results for the job.
    task automatic applyStimulus(input int n, input int m, input int p,
                                 input logic sm, input logic tb_mode,
                                 input logic [AW-1:0] a_base, input logic [AW-1:0] b_base,
                                 input logic [AW-1:0] c_base);
        longint          sacc;
        longint unsigned uacc;
        logic [AW-1:0]   ai, bi;
        res_t            r;
        @(negedge clk);
        N             = DIMW'(n);
        M             = DIMW'(m);
        P             = DIMW'(p);
        signed_mode   = sm;
        transpose_b   = tb_mode;
        matrix_a_addr = a_base;
        matrix_b_addr = b_base;
        matrix_c_addr = c_base;
        start         = 1'b1;
        exp_ovf       = 1'b0;
        exp_reads     = 0;
        if (n != 0 && m != 0 && p != 0) begin
            exp_reads = n * m * p;
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < p; j++) begin
                    sacc = 0;
                    uacc = 0;
                    for (int k = 0; k < m; k++) begin
                        ai = AW'(a_base + i * m + k);
                        bi = tb_mode ? AW'(b_base + j * m + k) : AW'(b_base + k * p + j);
                        exp_a_q.push_back(ai);
                        exp_b_q.push_back(bi);
                        sacc += longint'($signed(mem_a[ai])) * longint'($signed(mem_b[bi]));
                        uacc += {32'b0, mem_a[ai]} * {32'b0, mem_b[bi]};
                    end
                    r.data = sm ? sacc[31:0] : uacc[31:0];
                    r.row  = DIMW'(i);
                    r.col  = DIMW'(j);
                    r.addr = AW'(c_base + i * p + j);
                    exp_q.push_back(r);
                    if (sm ? (sacc > 64'sh7FFF_FFFF || sacc < -64'sh8000_0000)
                           : (uacc > 64'hFFFF_FFFF)) begin
                        exp_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    // ready_mode 0: always ready; 1: hold ready low for 5 valid cycles per
    // element; 2: random ready.
    task automatic runJob(input int ready_mode, input int budget, input int exp_first,
                          output int done_at);
        int   first_valid = -1;
        int   wait_cnt    = 0;
        int   a_reads     = 0;
        int   extra       = 0;
        bit   seen_done   = 0;
        res_t r;
        done_at = -1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = res_valid && (wait_cnt >= 5);
                default: res_ready = ($urandom_range(0, 1) == 1);
            endcase
            #1;
            if (seen_done) begin
                checkOutput("done_width", 64'(done), 64'(0));
                break;
            end
            if (cyc == 1) checkOutput("busy_after_start", 64'(busy), 64'(exp_first > 0));
            if (a_rd_en) begin
                a_reads++;
                if (exp_a_q.size() > 0) begin
                    checkOutput("a_rd_addr", 64'(a_rd_addr), 64'(exp_a_q.pop_front()));
                    checkOutput("b_rd_addr", 64'(b_rd_addr), 64'(exp_b_q.pop_front()));
                    checkOutput("b_rd_en", 64'(b_rd_en), 64'(1));
                end
            end
            if (res_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    r = exp_q[0];
                    checkOutput("result_out", 64'(result_out), 64'(r.data));
                    checkOutput("res_row", 64'(res_row), 64'(r.row));
                    checkOutput("res_col", 64'(res_col), 64'(r.col));
                    checkOutput("c_wr_en", 64'(c_wr_en), 64'(res_ready));
                    if (res_ready) begin
                        checkOutput("c_wr_addr", 64'(c_wr_addr), 64'(r.addr));
                        checkOutput("c_wr_data", 64'(c_wr_data), 64'(r.data));
                        void'(exp_q.pop_front());
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                checkOutput("c_wr_en_idle", 64'(c_wr_en), 64'(0));
            end
            if (done) begin
                seen_done = 1;
                done_at   = cyc;
                checkOutput("busy_at_done", 64'(busy), 64'(0));
            end
        end
        checkOutput("job_done", 64'(seen_done), 64'(1));
        checkOutput("first_valid_cycle", 64'(first_valid), 64'(exp_first));
        checkOutput("reads_issued", 64'(a_reads), 64'(exp_reads));
        checkOutput("results_pending", 64'(exp_q.size()), 64'(0));
        checkOutput("extra_results", 64'(extra), 64'(0));
    endtask

    task automatic clearQueues();
        exp_q.delete();
        exp_a_q.delete();
        exp_b_q.delete();
    endtask

    // Matrices used by the directed steps.
    int a2[4]  = '{1, 2, 3, 4};
    int b2[4]  = '{5, 6, 7, 8};
    int a3[12] = '{1, -1, 2, 3, -1, 4, -1, 0, 5, 6, 7, -1};
    int b3[8]  = '{2, -3, 1, 4, -1, 2, 3, -1};

    initial begin
        rst_n       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        signed_mode = 1'b0;
        transpose_b = 1'b0;
        matrix_a_addr = '0;
        matrix_b_addr = '0;
        matrix_c_addr = '0;
        N = '0;
        M = '0;
        P = '0;
        res_ready = 1'b0;
        for (int x = 0; x < 4096; x++) begin
            mem_a[x] = '0;
            mem_b[x] = '0;
        end
        for (int x = 0; x < 4; x++) begin
            mem_a[12'h100 + x] = 32'(a2[x]);
            mem_b[12'h200 + x] = 32'(b2[x]);
        end
        // A 3x4 placed so that it wraps past the top of the address space;
        // B 4x2 stored column-major (element [k][j] at b + j*4 + k).
        for (int x = 0; x < 12; x++) mem_a[AW'(12'hFFC + x)] = 32'(a3[x]);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 2; j++) mem_b[AW'(12'h500 + j * 4 + k)] = 32'(b3[k * 2 + j]);
        end
        mem_a[12'h020] = 32'hFFFF_FFFF;
        mem_b[12'h030] = 32'hFFFF_FFFF;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_res_valid", 64'(res_valid), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_err", 64'(err), 64'(0));
        checkOutput("rst_ovf", 64'(ovf), 64'(0));
        checkOutput("rst_a_rd_en", 64'(a_rd_en), 64'(0));
        checkOutput("rst_b_rd_en", 64'(b_rd_en), 64'(0));
        checkOutput("rst_c_wr_en", 64'(c_wr_en), 64'(0));
        checkOutput("rst_result_out", 64'(result_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] 2x2x2 unsigned");
        applyStimulus(2, 2, 2, 1'b0, 1'b0, 12'h100, 12'h200, 12'h300);
        runJob(0, 60, 4, done_cyc);
        checkOutput("2x2_err", 64'(err), 64'(0));
        checkOutput("2x2_ovf", 64'(ovf), 64'(exp_ovf));

        $display("[TB] 3x4x2 signed, transposed B, wrapping A");
        applyStimulus(3, 4, 2, 1'b1, 1'b1, 12'hFFC, 12'h500, 12'h600);
        runJob(0, 200, 6, done_cyc);
        checkOutput("3x4_ovf", 64'(ovf), 64'(exp_ovf));

        $display("[TB] backpressure");
        applyStimulus(2, 2, 2, 1'b0, 1'b0, 12'h100, 12'h200, 12'h300);
        runJob(1, 200, 4, done_cyc);
        applyStimulus(3, 4, 2, 1'b1, 1'b1, 12'hFFC, 12'h500, 12'h600);
        runJob(2, 600, 6, done_cyc);

        $display("[TB] 1x1x1 overflow");
        applyStimulus(1, 1, 1, 1'b0, 1'b0, 12'h020, 12'h030, 12'h040);
        runJob(0, 20, 3, done_cyc);
        checkOutput("ovf_unsigned", 64'(ovf), 64'(exp_ovf));
        applyStimulus(1, 1, 1, 1'b1, 1'b0, 12'h020, 12'h030, 12'h040);
        runJob(0, 20, 3, done_cyc);
        checkOutput("ovf_signed", 64'(ovf), 64'(exp_ovf));

        $display("[TB] zero dimension");
        applyStimulus(2, 0, 2, 1'b0, 1'b0, 12'h100, 12'h200, 12'h300);
        runJob(0, 10, -1, done_cyc);
        checkOutput("zero_dim_done_cycle", 64'(done_cyc), 64'(1));
        checkOutput("zero_dim_err", 64'(err), 64'(1));
        repeat (3) @(negedge clk);
        #1 checkOutput("err_holds", 64'(err), 64'(1));

        $display("[TB] abort during fetch");
        applyStimulus(2, 4, 2, 1'b0, 1'b0, 12'h100, 12'h200, 12'h300);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_a_rd_en", 64'(a_rd_en), 64'(0));
        checkOutput("abort_err", 64'(err), 64'(0));
        for (int x = 0; x < 4; x++) begin
            @(negedge clk);
            #1 checkOutput("abort_no_done", 64'(done), 64'(0));
        end
        clearQueues();

        $display("[TB] reset during emit");
        applyStimulus(2, 2, 2, 1'b0, 1'b0, 12'h100, 12'h200, 12'h300);
        res_ready = 1'b0;
        for (int x = 0; x < 20; x++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (res_valid) break;
        end
        checkOutput("emit_reached", 64'(res_valid), 64'(1));
        checkOutput("emit_result", 64'(result_out), 64'(exp_q[0].data));
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", 64'(res_valid), 64'(0));
        checkOutput("rst_mid_busy", 64'(busy), 64'(0));
        checkOutput("rst_mid_result", 64'(result_out), 64'(0));
        for (int x = 0; x < 3; x++) begin
            @(negedge clk);
            #1 checkOutput("rst_mid_no_done", 64'(done), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        clearQueues();

        $display("[TB] job after reset");
        applyStimulus(2, 2, 2, 1'b0, 1'b0, 12'h100, 12'h200, 12'h300);
        runJob(0, 60, 4, done_cyc);
        checkOutput("final_err", 64'(err), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
